// File: rtl/bus_dma_host_if.sv
// Bus bundle for the DMA engine: the register device port and the host initiator port.
// Host handshake: req stays high with addr/we/be/wdata frozen until the cycle gnt is seen;
// one transaction is outstanding until its rvalid (err qualified by rvalid) returns.
interface bus_dma_host_if #(
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32
);
    logic                    dev_req_i;
    logic                    dev_we_i;
    logic [3:0]              dev_be_i;
    logic [AddressWidth-1:0] dev_addr_i;
    logic [DataWidth-1:0]    dev_wdata_i;
    logic                    dev_rvalid_o;
    logic [DataWidth-1:0]    dev_rdata_o;
    logic                    dev_err_o;

    logic                    host_req_o;
    logic                    host_gnt_i;
    logic [AddressWidth-1:0] host_addr_o;
    logic                    host_we_o;
    logic [3:0]              host_be_o;
    logic [DataWidth-1:0]    host_wdata_o;
    logic                    host_rvalid_i;
    logic [DataWidth-1:0]    host_rdata_i;
    logic                    host_err_i;

    // slave: the DMA engine's view
    modport slave (
        input  dev_req_i, dev_we_i, dev_be_i, dev_addr_i, dev_wdata_i,
        output dev_rvalid_o, dev_rdata_o, dev_err_o,
        output host_req_o, host_addr_o, host_we_o, host_be_o, host_wdata_o,
        input  host_gnt_i, host_rvalid_i, host_rdata_i, host_err_i
    );

    // master: the system side (core on the device port, memory on the host port)
    modport master (
        output dev_req_i, dev_we_i, dev_be_i, dev_addr_i, dev_wdata_i,
        input  dev_rvalid_o, dev_rdata_o, dev_err_o,
        input  host_req_o, host_addr_o, host_we_o, host_be_o, host_wdata_o,
        output host_gnt_i, host_rvalid_i, host_rdata_i, host_err_i
    );
endinterface

// File: rtl/bus_dma_host.sv
// Single-channel word-copy DMA: config/status registers on the device port and a
// host initiator copying LEN words from SRC to DST, one bus transaction at a time.
module bus_dma_host #(
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32,
    parameter int LenWidth     = 16
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    bus_dma_host_if.slave bus,
    output logic          dma_intr_o,
    output logic [2:0]    dbg_state_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        WR_WAIT = 3'd4
    } state_e;

    state_e state_q, state_d;

    logic [AddressWidth-1:0] src_q, dst_q, cur_src_q, cur_dst_q;
    logic [LenWidth-1:0]     len_q, remaining_q;
    logic [DataWidth-1:0]    buf_q;
    logic                    ie_q, done_q, err_q, zero_pend_q;
    logic                    dev_rvalid_q, dev_err_q;
    logic [DataWidth-1:0]    dev_rdata_q;
    logic [3:0]              be_q;

    logic [7:0]              offset;
    logic                    dev_wr, busy, start;
    logic                    rsp_ok, rsp_err, xfer_done;
    logic [DataWidth-1:0]    rd_val;
    logic                    rd_unmapped;

    logic                    host_req;
    logic                    host_we;
    logic [AddressWidth-1:0] host_addr;

    logic                    unused_bits;
    assign unused_bits = ^{bus.dev_be_i, bus.dev_addr_i[AddressWidth-1:10], bus.dev_addr_i[1:0]};

    assign offset    = bus.dev_addr_i[9:2];
    assign dev_wr    = bus.dev_req_i & bus.dev_we_i;
    assign busy      = (state_q != IDLE) | zero_pend_q;
    assign start     = dev_wr & (offset == 8'h03) & bus.dev_wdata_i[0] & ~busy;
    assign rsp_ok    = bus.host_rvalid_i & ~bus.host_err_i;
    assign rsp_err   = bus.host_rvalid_i & bus.host_err_i &
                       ((state_q == RD_WAIT) | (state_q == WR_WAIT));
    assign xfer_done = (state_q == WR_WAIT) & rsp_ok & (remaining_q == LenWidth'(1));

    always_comb begin
        rd_val      = '0;
        rd_unmapped = 1'b0;
        case (offset)
            8'h00:   rd_val = DataWidth'(src_q);
            8'h01:   rd_val = DataWidth'(dst_q);
            8'h02:   rd_val = DataWidth'(len_q);
            8'h03:   rd_val[1] = ie_q;
            8'h04:   rd_val[2:0] = {err_q, done_q, busy};
            default: rd_unmapped = 1'b1;
        endcase
    end

    // Register file and device-port response; reads see the value before this edge's write.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            src_q        <= '0;
            dst_q        <= '0;
            len_q        <= '0;
            ie_q         <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            zero_pend_q  <= 1'b0;
            dev_rvalid_q <= 1'b0;
            dev_rdata_q  <= '0;
            dev_err_q    <= 1'b0;
            be_q         <= 4'h0;
        end else begin
            be_q         <= 4'hF;
            dev_rvalid_q <= bus.dev_req_i;
            dev_rdata_q  <= bus.dev_req_i ? rd_val : '0;
            dev_err_q    <= bus.dev_req_i & rd_unmapped;
            if (dev_wr && !busy) begin
                case (offset)
                    8'h00:   src_q <= {bus.dev_wdata_i[AddressWidth-1:2], 2'b00};
                    8'h01:   dst_q <= {bus.dev_wdata_i[AddressWidth-1:2], 2'b00};
                    8'h02:   len_q <= bus.dev_wdata_i[LenWidth-1:0];
                    default: ;
                endcase
            end
            if (dev_wr && offset == 8'h03) ie_q <= bus.dev_wdata_i[1];
            if (dev_wr && offset == 8'h04) begin
                if (bus.dev_wdata_i[1]) done_q <= 1'b0;
                if (bus.dev_wdata_i[2]) err_q  <= 1'b0;
            end
            zero_pend_q <= start & (len_q == '0);
            if (start) begin
                done_q <= 1'b0;
                err_q  <= 1'b0;
            end
            if (zero_pend_q || xfer_done) done_q <= 1'b1;
            if (rsp_err) begin
                err_q  <= 1'b1;
                done_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cur_src_q   <= '0;
            cur_dst_q   <= '0;
            remaining_q <= '0;
            buf_q       <= '0;
        end else begin
            if (start) begin
                cur_src_q   <= src_q;
                cur_dst_q   <= dst_q;
                remaining_q <= len_q;
            end
            if (state_q == RD_WAIT && rsp_ok) buf_q <= bus.host_rdata_i;
            // Address arithmetic wraps silently at the top of the address space.
            if (state_q == WR_WAIT && rsp_ok) begin
                cur_src_q   <= cur_src_q + AddressWidth'(4);
                cur_dst_q   <= cur_dst_q + AddressWidth'(4);
                remaining_q <= remaining_q - LenWidth'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        host_req  = 1'b0;
        host_we   = 1'b0;
        host_addr = '0;
        unique case (state_q)
            IDLE: begin
                if (start && len_q != '0) state_d = RD_REQ;
            end
            RD_REQ: begin
                host_req  = 1'b1;
                host_addr = cur_src_q;
                if (bus.host_gnt_i) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (bus.host_rvalid_i) state_d = bus.host_err_i ? IDLE : WR_REQ;
            end
            WR_REQ: begin
                host_req  = 1'b1;
                host_we   = 1'b1;
                host_addr = cur_dst_q;
                if (bus.host_gnt_i) state_d = WR_WAIT;
            end
            WR_WAIT: begin
                if (bus.host_rvalid_i) begin
                    if (bus.host_err_i || remaining_q == LenWidth'(1)) state_d = IDLE;
                    else                                                state_d = RD_REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.host_req_o   = host_req;
    assign bus.host_we_o    = host_we;
    assign bus.host_addr_o  = host_addr;
    assign bus.host_be_o    = be_q;
    assign bus.host_wdata_o = buf_q;
    assign bus.dev_rvalid_o = dev_rvalid_q;
    assign bus.dev_rdata_o  = dev_rdata_q;
    assign bus.dev_err_o    = dev_err_q;
    assign dma_intr_o       = done_q & ie_q;
    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_bus_dma_host.sv
// Bench for bus_dma_host: a memory responder on the host port and register
// driver tasks on the device port, checked against a word-copy reference model.
module tb_bus_dma_host;

  localparam logic [9:0] OFF_SRC    = 10'h000;
  localparam logic [9:0] OFF_DST    = 10'h004;
  localparam logic [9:0] OFF_LEN    = 10'h008;
  localparam logic [9:0] OFF_CTRL   = 10'h00C;
  localparam logic [9:0] OFF_STATUS = 10'h010;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       dma_intr;
  logic [2:0] dbg_state;

  bus_dma_host_if #(.DataWidth(32), .AddressWidth(32)) bus ();

  bus_dma_host #(.DataWidth(32), .AddressWidth(32), .LenWidth(16)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .bus        (bus),
    .dma_intr_o (dma_intr),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // memory behind the host port, plus what the responder observed
  logic [31:0] mem [logic [31:0]];
  logic [63:0] wr_log[$];
  int rd_count, wr_count, err_rd_idx, err_wr_idx;
  int force_stall, wr_grants, req_cycles;
  int stall_left, pend_wait;
  bit in_req, pend, granted_last;
  logic [31:0] lat_addr, lat_wdata;
  logic lat_we;

  // reference model outputs
  logic [63:0] exp_q[$];
  int exp_reads;
  logic [2:0] exp_status;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic responder();
    forever begin
      @(negedge clk);
      bus.host_gnt_i = 1'b0;
      bus.host_rvalid_i = 1'b0;
      bus.host_err_i = 1'b0;
      bus.host_rdata_i = '0;
      if (!rst_ni) begin
        in_req = 0;
        pend = 0;
        granted_last = 0;
      end else begin
        if (bus.host_req_o === 1'b1) req_cycles++;
        if (granted_last) begin
          tests_run++;
          if (bus.host_req_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL req_drop: host_req_o=%b after grant, want 0", bus.host_req_o);
          end
        end
        granted_last = 0;
        if (pend) begin
          if (pend_wait > 0) pend_wait--;
          else begin
            pend = 0;
            bus.host_rvalid_i = 1'b1;
            if (!lat_we) begin
              rd_count++;
              bus.host_rdata_i = mem_rd(lat_addr);
              bus.host_err_i = (rd_count == err_rd_idx);
            end else begin
              wr_count++;
              if (wr_count == err_wr_idx) bus.host_err_i = 1'b1;
              else begin
                mem[lat_addr] = lat_wdata;
                wr_log.push_back({lat_addr, lat_wdata});
              end
            end
          end
        end else if (bus.host_req_o === 1'b1) begin
          if (!in_req) begin
            in_req = 1;
            lat_addr = bus.host_addr_o;
            lat_we = bus.host_we_o;
            lat_wdata = bus.host_wdata_o;
            stall_left = (force_stall > 0) ? force_stall : $urandom_range(0, 2);
          end else begin
            tests_run++;
            if ({bus.host_addr_o, bus.host_we_o, bus.host_wdata_o} !== {lat_addr, lat_we, lat_wdata}) begin
              tests_failed++;
              $display("FAIL req_stable: addr=%h we=%b wdata=%h, want addr=%h we=%b wdata=%h",
                       bus.host_addr_o, bus.host_we_o, bus.host_wdata_o, lat_addr, lat_we, lat_wdata);
            end
          end
          if (stall_left > 0) stall_left--;
          else begin
            tests_run++;
            if (bus.host_be_o !== 4'hF || bus.host_addr_o[1:0] !== 2'b00) begin
              tests_failed++;
              $display("FAIL req_shape: be=%h addr=%h, want be=f and word-aligned addr",
                       bus.host_be_o, bus.host_addr_o);
            end
            bus.host_gnt_i = 1'b1;
            in_req = 0;
            pend = 1;
            pend_wait = $urandom_range(0, 1);
            granted_last = 1;
            if (lat_we) wr_grants++;
          end
        end else if (in_req) begin
          tests_run++;
          tests_failed++;
          $display("FAIL req_abandon: host_req_o=0 before grant, want 1");
          in_req = 0;
        end
      end
    end
  endtask

  task automatic dev_write(input logic [9:0] off, input logic [31:0] data);
    bus.dev_req_i = 1'b1;
    bus.dev_we_i = 1'b1;
    bus.dev_be_i = 4'hF;
    bus.dev_addr_i = 32'(off);
    bus.dev_wdata_i = data;
    @(negedge clk);
    bus.dev_req_i = 1'b0;
    bus.dev_we_i = 1'b0;
  endtask

  task automatic dev_read(input logic [9:0] off, output logic [31:0] data, output logic err, output logic rv);
    bus.dev_req_i = 1'b1;
    bus.dev_we_i = 1'b0;
    bus.dev_be_i = 4'hF;
    bus.dev_addr_i = 32'(off);
    @(negedge clk);
    data = bus.dev_rdata_o;
    err = bus.dev_err_o;
    rv = bus.dev_rvalid_o;
    bus.dev_req_i = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    logic [31:0] d;
    logic e, rv;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      dev_read(OFF_STATUS, d, e, rv);
      if (rv === 1'b1 && d[0] === 1'b0) begin
        ok = 1;
        break;
      end
    end
  endtask

  // Word-copy model: read i then write i, stopping at the first bus error.
  task automatic model_prepare(input logic [31:0] src, input logic [31:0] dst, input int len,
                               input int e_rd, input int e_wr);
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] s, d, v;
    ref_mem = mem;
    exp_q.delete();
    exp_reads = 0;
    exp_status = 3'b010;
    s = src & ~32'h3;
    d = dst & ~32'h3;
    for (int i = 1; i <= len; i++) begin
      exp_reads = i;
      if (i == e_rd) begin
        exp_status = 3'b100;
        break;
      end
      v = ref_mem.exists(s) ? ref_mem[s] : (s ^ 32'h5A5A_0F0F);
      if (i == e_wr) begin
        exp_status = 3'b100;
        break;
      end
      ref_mem[d] = v;
      exp_q.push_back({d, v});
      s = s + 32'd4;
      d = d + 32'd4;
    end
    wr_log.delete();
    rd_count = 0;
    wr_count = 0;
    err_rd_idx = e_rd;
    err_wr_idx = e_wr;
  endtask

  task automatic start_xfer(input logic [31:0] src, input logic [31:0] dst, input int len, input bit ie);
    dev_write(OFF_SRC, src);
    dev_write(OFF_DST, dst);
    dev_write(OFF_LEN, 32'(len));
    dev_write(OFF_CTRL, {30'h0, ie, 1'b1});
  endtask

  task automatic finish_check(input string name, input bit ie);
    bit ok;
    logic [31:0] d;
    logic e, rv;
    wait_idle(ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL %s_timeout: busy still set after 400 polls, want idle", name);
    end
    tests_run++;
    if (wr_log.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL %s_wr_count: got %0d writes, want %0d", name, wr_log.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        tests_run++;
        if (wr_log[i] !== exp_q[i]) begin
          tests_failed++;
          $display("FAIL %s_wr[%0d]: got addr/data %h, want %h", name, i, wr_log[i], exp_q[i]);
        end
      end
    end
    tests_run++;
    if (rd_count != exp_reads) begin
      tests_failed++;
      $display("FAIL %s_rd_count: got %0d reads, want %0d", name, rd_count, exp_reads);
    end
    dev_read(OFF_STATUS, d, e, rv);
    tests_run++;
    if (d !== {29'h0, exp_status}) begin
      tests_failed++;
      $display("FAIL %s_status: got %h, want %h", name, d, {29'h0, exp_status});
    end
    tests_run++;
    if (dma_intr !== (ie & exp_status[1])) begin
      tests_failed++;
      $display("FAIL %s_intr: got %b, want %b", name, dma_intr, ie & exp_status[1]);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic e, rv;
    logic [9:0] offs [5];
    offs = '{OFF_SRC, OFF_DST, OFF_LEN, OFF_CTRL, OFF_STATUS};
    rst_ni = 1'b0;
    bus.dev_req_i = 1'b0;
    bus.dev_we_i = 1'b0;
    bus.dev_be_i = 4'h0;
    bus.dev_addr_i = '0;
    bus.dev_wdata_i = '0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({bus.host_req_o, bus.host_we_o, bus.host_be_o, bus.host_addr_o, bus.host_wdata_o,
         bus.dev_rvalid_o, bus.dev_err_o, bus.dev_rdata_o, dma_intr} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: req=%b we=%b be=%h addr=%h wdata=%h rvalid=%b intr=%b, want all 0",
               bus.host_req_o, bus.host_we_o, bus.host_be_o, bus.host_addr_o, bus.host_wdata_o,
               bus.dev_rvalid_o, dma_intr);
    end
    rst_ni = 1'b1;
    @(negedge clk);
    foreach (offs[i]) begin
      dev_read(offs[i], d, e, rv);
      tests_run++;
      if ({rv, e, d} !== {1'b1, 1'b0, 32'h0}) begin
        tests_failed++;
        $display("FAIL reset_reg[%h]: got rv=%b err=%b data=%h, want 1/0/0", offs[i], rv, e, d);
      end
    end
  endtask

  task automatic test_regs();
    logic [31:0] d;
    logic e, rv;
    logic [9:0]  offs [7];
    logic [31:0] exps [7];
    logic        errs [7];
    dev_write(OFF_SRC, 32'h0010_0003);
    dev_write(OFF_DST, 32'hFFFF_FFFF);
    dev_write(OFF_LEN, 32'h0001_2345);
    dev_write(OFF_CTRL, 32'h0000_0002);
    @(negedge clk);
    tests_run++;
    if (bus.dev_rvalid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL rvalid_pulse: dev_rvalid_o=%b with no request, want 0", bus.dev_rvalid_o);
    end
    offs = '{OFF_SRC, OFF_DST, OFF_LEN, OFF_CTRL, 10'h014, 10'h3FC, 10'h000};
    exps = '{32'h0010_0000, 32'hFFFF_FFFC, 32'h0000_2345, 32'h0000_0002, 32'h0, 32'h0, 32'h0010_0000};
    errs = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    foreach (offs[i]) begin
      dev_read(offs[i], d, e, rv);
      tests_run++;
      if ({rv, e, d} !== {1'b1, errs[i], exps[i]}) begin
        tests_failed++;
        $display("FAIL reg_rd[%h]: got rv=%b err=%b data=%h, want 1/%b/%h", offs[i], rv, e, d, errs[i], exps[i]);
      end
    end
    dev_write(OFF_CTRL, 32'h0);
  endtask

  task automatic test_basic();
    logic [31:0] d;
    logic e, rv;
    for (int i = 0; i < 4; i++) mem[32'h0010_0000 + 32'(4 * i)] = 32'hA0 + 32'(i);
    model_prepare(32'h0010_0000, 32'h0010_0100, 4, 0, 0);
    start_xfer(32'h0010_0000, 32'h0010_0100, 4, 1'b1);
    finish_check("basic", 1'b1);
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (mem[32'h0010_0100 + 32'(4 * i)] !== 32'hA0 + 32'(i)) begin
        tests_failed++;
        $display("FAIL basic_mem[%0d]: got %h, want %h", i, mem[32'h0010_0100 + 32'(4 * i)], 32'hA0 + 32'(i));
      end
    end
    dev_write(OFF_STATUS, 32'h2);
    dev_read(OFF_STATUS, d, e, rv);
    tests_run++;
    if (d !== 32'h0 || dma_intr !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_w1c: status=%h intr=%b, want 0/0", d, dma_intr);
    end
  endtask

  task automatic test_zero_len();
    int base;
    model_prepare(32'h0000_7000, 32'h0000_7100, 0, 0, 0);
    base = req_cycles;
    start_xfer(32'h0000_7000, 32'h0000_7100, 0, 1'b1);
    tests_run++;
    if (dma_intr !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_early: intr=%b right after start, want 0", dma_intr);
    end
    @(negedge clk);
    tests_run++;
    if (dma_intr !== 1'b1) begin
      tests_failed++;
      $display("FAIL zero_done: intr=%b one cycle after start, want 1", dma_intr);
    end
    finish_check("zero", 1'b1);
    tests_run++;
    if (req_cycles != base) begin
      tests_failed++;
      $display("FAIL zero_req: %0d host_req cycles, want 0", req_cycles - base);
    end
  endtask

  task automatic test_read_error();
    model_prepare(32'h0020_0000, 32'h0020_0100, 4, 2, 0);
    start_xfer(32'h0020_0000, 32'h0020_0100, 4, 1'b1);
    finish_check("rd_err", 1'b1);
    tests_run++;
    if (wr_log.size() != 1) begin
      tests_failed++;
      $display("FAIL rd_err_words: got %0d words written, want 1", wr_log.size());
    end
  endtask

  task automatic test_stall();
    force_stall = 5;
    model_prepare(32'h0030_0000, 32'h0030_0100, 2, 0, 0);
    start_xfer(32'h0030_0000, 32'h0030_0100, 2, 1'b0);
    finish_check("stall", 1'b0);
    force_stall = 0;
  endtask

  task automatic test_busy_write();
    logic [31:0] d;
    logic e, rv;
    force_stall = 1;
    model_prepare(32'h0000_2000, 32'h0000_3000, 6, 0, 0);
    start_xfer(32'h0000_2000, 32'h0000_3000, 6, 1'b0);
    dev_write(OFF_SRC, 32'hDEAD_0000);
    dev_write(OFF_DST, 32'hBEEF_0000);
    dev_write(OFF_LEN, 32'h1);
    dev_write(OFF_CTRL, 32'h3);
    dev_read(OFF_SRC, d, e, rv);
    tests_run++;
    if (d !== 32'h0000_2000) begin
      tests_failed++;
      $display("FAIL busy_src: got %h while busy, want 00002000", d);
    end
    finish_check("busy", 1'b1);
    dev_read(OFF_LEN, d, e, rv);
    tests_run++;
    if (d !== 32'h6) begin
      tests_failed++;
      $display("FAIL busy_len: got %h after transfer, want 6", d);
    end
    force_stall = 0;
  endtask

  task automatic test_wrap();
    model_prepare(32'hFFFF_FFF8, 32'h0000_0010, 4, 0, 0);
    start_xfer(32'hFFFF_FFF8, 32'h0000_0010, 4, 1'b1);
    finish_check("wrap", 1'b1);
  endtask

  task automatic test_random();
    logic [31:0] src, dst;
    int len, e_rd, e_wr;
    bit ie;
    for (int n = 0; n < 6; n++) begin
      src = 32'h0800_0000 + 32'($urandom_range(0, 31) << 2) + 32'($urandom_range(0, 3));
      dst = 32'h0800_0000 + 32'($urandom_range(0, 31) << 2) + 32'($urandom_range(0, 3));
      len = $urandom_range(1, 6);
      ie = 1'($urandom_range(0, 1));
      e_rd = 0;
      e_wr = 0;
      case ($urandom_range(0, 3))
        0: e_rd = $urandom_range(1, len);
        1: e_wr = $urandom_range(1, len);
        default: ;
      endcase
      model_prepare(src, dst, len, e_rd, e_wr);
      start_xfer(src, dst, len, ie);
      finish_check("random", ie);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic e, rv;
    bit ok;
    int base;
    logic [9:0] offs [5];
    offs = '{OFF_SRC, OFF_DST, OFF_LEN, OFF_CTRL, OFF_STATUS};
    model_prepare(32'h0000_4000, 32'h0000_5000, 4, 0, 0);
    base = wr_grants;
    start_xfer(32'h0000_4000, 32'h0000_5000, 4, 1'b1);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (wr_grants > base) begin
        ok = 1;
        break;
      end
    end
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL rstmid_timeout: no write granted in 200 cycles, want one");
    end
    #1;
    rst_ni = 1'b0;
    #1;
    tests_run++;
    if ({bus.host_req_o, bus.host_we_o, bus.host_be_o, bus.host_addr_o, bus.host_wdata_o,
         bus.dev_rvalid_o, bus.dev_err_o, bus.dev_rdata_o, dma_intr} !== '0) begin
      tests_failed++;
      $display("FAIL rstmid_outputs: req=%b we=%b be=%h addr=%h wdata=%h intr=%b, want all 0",
               bus.host_req_o, bus.host_we_o, bus.host_be_o, bus.host_addr_o, bus.host_wdata_o, dma_intr);
    end
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    base = req_cycles;
    foreach (offs[i]) begin
      dev_read(offs[i], d, e, rv);
      tests_run++;
      if (d !== 32'h0) begin
        tests_failed++;
        $display("FAIL rstmid_reg[%h]: got %h after reset, want 0", offs[i], d);
      end
    end
    tests_run++;
    if (req_cycles != base) begin
      tests_failed++;
      $display("FAIL rstmid_req: %0d host_req cycles after reset, want 0", req_cycles - base);
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    force_stall = 0;
    wr_grants = 0;
    req_cycles = 0;
    rd_count = 0;
    wr_count = 0;
    err_rd_idx = 0;
    err_wr_idx = 0;
    fork
      responder();
    join_none
    test_reset();
    test_regs();
    test_basic();
    test_zero_len();
    test_read_error();
    test_stall();
    test_busy_write();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in 50000 cycles");
    $fatal(1);
  end

endmodule
